alu_cmd_scheduler: RTL
======================

# alu_cmd_scheduler

Frame-level controller between the UART receiver/transmitter and the combinational ALU. It collects a three-byte command frame (operand A, operand B, opcode), validates the opcode and presents stable operands to the ALU. It then launches exactly one UART transmission of the result and waits for the transmitter to finish before accepting the next frame. An optional inter-byte timeout discards partial frames.

## Interface
- NB_DATA, 8, operand/result/UART byte width
- NB_OPCODE, 6, ALU opcode width (≤ NB_DATA)
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clock cycles (10 ms at 100 MHz)
- NB_TIMEOUT, $clog2(TIMEOUT_CYCLES), timeout counter width

- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  received byte, valid only with i_rx_data_valid
- i_rx_data_valid  in  1  one-cycle pulse per received byte
- i_alu_result  in  NB_DATA  combinational ALU result
- i_tx_done  in  1  one-cycle pulse when the UART has finished sending the stop bit
- o_first_operator  out  NB_DATA  operand A to the ALU
- o_second_operator  out  NB_DATA  operand B to the ALU
- o_opcode  out  NB_OPCODE  opcode to the ALU
- o_tx_data  out  NB_DATA  byte to transmit, held from o_tx_start until i_tx_done
- o_tx_start  out  1  one-cycle transmit request
- o_busy  out  1  high in every state except IDLE
- o_err_opcode  out  1  one-cycle pulse when a frame is rejected
- o_overrun  out  1  one-cycle pulse when a byte is dropped
- o_timeout  out  1  one-cycle pulse when a partial frame is discarded
- o_state  out  3  current state encoding, for debug LEDs

## Operation
- States: IDLE → GET_B → GET_OP → EXEC → SEND → WAIT_TX → IDLE.
- IDLE: a valid byte is latched into o_first_operator; go to GET_B.
- GET_B: a valid byte is latched into o_second_operator; go to GET_OP.
- GET_OP: on a valid byte, go to EXEC.
  - The opcode is legal when bits [NB_DATA-1:NB_OPCODE] are zero and bits [NB_OPCODE-1:0] are in the legal set (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010).
  - If legal, latch the byte into o_opcode.
  - If illegal, leave o_opcode unchanged, set an internal reject flag and pulse o_err_opcode.
- EXEC: load o_tx_data with i_alu_result, or with ERR_BYTE (8'hEE) when the reject flag is set; go to SEND.
- SEND: o_tx_start is high for this single cycle; go to WAIT_TX.
- WAIT_TX: stay until i_tx_done; then clear the reject flag and return to IDLE.
- Any i_rx_data_valid seen in EXEC, SEND or WAIT_TX is dropped and pulses o_overrun. This includes a byte arriving in the same cycle as i_tx_done.
- i_tx_done outside WAIT_TX is ignored.
- Operand and opcode registers hold their values until overwritten by the next frame.

## Timing
- Reset values: all outputs 0, state IDLE, reject flag 0, timeout counter 0.
- Reset is asynchronous and may assert in any state, including mid-frame and WAIT_TX. The block returns to IDLE immediately and never emits o_tx_start during or on exit from reset.
- Latency: if the opcode byte's valid pulse is sampled at edge N, then:
  - o_opcode updates after edge N;
  - o_tx_data is loaded at edge N+1;
  - o_tx_start is high for the cycle following edge N+2.
- ALU operands are stable for at least one full cycle before o_tx_data is sampled.
- o_err_opcode, o_overrun and o_timeout are registered, single-cycle pulses.

## Configuration
- ALU_CMD_TIMEOUT_EN defined:
  - In GET_B and GET_OP, a counter runs and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, the state returns to IDLE and o_timeout pulses.
  - If a byte arrives in that same cycle, the byte wins and no timeout occurs.
- ALU_CMD_TIMEOUT_EN undefined: no counter is built, o_timeout is tied 0, and partial frames wait indefinitely.

## Structure
- Package alu_cmd_pkg holds:
  - the state encoding localparams (IDLE=0 … WAIT_TX=5);
  - the legal opcode constants;
  - ERR_BYTE.
- Sub-module alu_cmd_timeout: loadable down-counter with clear and expire outputs, instantiated only under ALU_CMD_TIMEOUT_EN.

## Test plan
- Frame 0x05, 0x03, 0x20 (ADD) → o_tx_data=0x08, one o_tx_start pulse exactly 2 cycles after the opcode valid. Pulse i_tx_done → o_busy drops the next cycle.
- Frame 0x0F, 0x01, 0x3F (illegal opcode) → o_err_opcode pulse, o_tx_data=0xEE, o_opcode unchanged. The next frame 0x0A, 0x04, 0x22 (SUB) → 0x06.
- A byte injected in WAIT_TX, including in the same cycle as i_tx_done → o_overrun pulse, state IDLE, o_first_operator unchanged.
- With ALU_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: send one byte, then wait 16 cycles → o_timeout pulse and IDLE. A byte arriving at count 15 → no timeout.
- Assert i_reset low during WAIT_TX and during GET_OP → all outputs 0, no o_tx_start. After release, a full frame executes normally.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - state encoding, legal ALU opcodes and error byte for alu_cmd_scheduler
package alu_cmd_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_B   = 3'd1;
  localparam logic [2:0] ST_GET_OP  = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam logic [7:0] ERR_BYTE = 8'hEE;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_timeout.sv
// rtl/alu_cmd_timeout.sv - loadable down-counter that flags an inter-byte timeout
module alu_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned NB_TIMEOUT     = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [NB_TIMEOUT-1:0] LOAD_VAL = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] count_q, count_d;

  assign o_expire = i_enable && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (i_clear || o_expire) begin
      count_d = LOAD_VAL;
    end else if (i_enable) begin
      count_d = count_q - NB_TIMEOUT'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_scheduler.sv
// rtl/alu_cmd_scheduler.sv - UART frame collector driving the ALU and one result transmission
// Optional inter-byte timeout built when ALU_CMD_TIMEOUT_EN is defined.
module alu_cmd_scheduler
  import alu_cmd_pkg::*;
#(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OPCODE      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned NB_TIMEOUT     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_data_valid,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_tx_done,
  output logic [NB_DATA-1:0]   o_first_operator,
  output logic [NB_DATA-1:0]   o_second_operator,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_err_opcode,
  output logic                 o_overrun,
  output logic                 o_timeout,
  output logic [2:0]           o_state
);

  logic [2:0]           state_q, state_d;
  logic [NB_DATA-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, tx_data_q, tx_data_d;
  logic [NB_OPCODE-1:0] opcode_q, opcode_d;
  logic                 reject_q, reject_d;
  logic                 tx_start_q, tx_start_d;
  logic                 err_q, err_d, overrun_q, overrun_d, timeout_q, timeout_d;
  logic                 opcode_legal;
  logic                 timer_expire;

  assign opcode_legal = ((i_rx_data >> NB_OPCODE) == '0) &&
                        is_legal_op(6'(i_rx_data[NB_OPCODE-1:0]));

`ifdef ALU_CMD_TIMEOUT_EN
  logic timer_run;

  assign timer_run = (state_q == ST_GET_B) || (state_q == ST_GET_OP);

  alu_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .NB_TIMEOUT     (NB_TIMEOUT)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (!timer_run || i_rx_data_valid),
    .i_enable (timer_run && !i_rx_data_valid),
    .o_expire (timer_expire)
  );
`else
  assign timer_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    opcode_d   = opcode_q;
    tx_data_d  = tx_data_q;
    reject_d   = reject_q;
    tx_start_d = (state_q == ST_SEND);
    err_d      = 1'b0;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (i_rx_data_valid) begin
        op_a_d  = i_rx_data;
        state_d = ST_GET_B;
      end
      ST_GET_B: if (i_rx_data_valid) begin
        op_b_d  = i_rx_data;
        state_d = ST_GET_OP;
      end else if (timer_expire) begin
        state_d   = ST_IDLE;
        timeout_d = 1'b1;
      end
      ST_GET_OP: if (i_rx_data_valid) begin
        state_d = ST_EXEC;
        if (opcode_legal) begin
          opcode_d = i_rx_data[NB_OPCODE-1:0];
        end else begin
          reject_d = 1'b1;
          err_d    = 1'b1;
        end
      end else if (timer_expire) begin
        state_d   = ST_IDLE;
        timeout_d = 1'b1;
      end
      ST_EXEC: begin
        tx_data_d = reject_q ? NB_DATA'(ERR_BYTE) : i_alu_result;
        state_d   = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) begin
        reject_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Bytes arriving after the opcode until the transmitter is free are lost.
    if (i_rx_data_valid && ((state_q == ST_EXEC) || (state_q == ST_SEND) ||
                            (state_q == ST_WAIT_TX))) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      reject_q   <= 1'b0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      reject_q   <= reject_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_first_operator  = op_a_q;
  assign o_second_operator = op_b_q;
  assign o_opcode          = opcode_q;
  assign o_tx_data         = tx_data_q;
  assign o_tx_start        = tx_start_q;
  assign o_busy            = (state_q != ST_IDLE);
  assign o_err_opcode      = err_q;
  assign o_overrun         = overrun_q;
  assign o_timeout         = timeout_q;
  assign o_state           = state_q;

endmodule
